// File: rtl/muldiv_unit.sv
// muldiv_unit: RISC-V M-extension multiply/divide unit.
// Multiplies finish in one cycle. Divides run a radix-2 restoring loop for XLEN cycles.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   in_valid/in_ready    request handshake; funct3 selects the op, op_a/op_b are rs1/rs2
//   flush                synchronous abort of the operation in flight
//   out_valid/out_ready  result handshake; result is registered
//   busy                 high while a multiply or divide is computing
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   a_q, a_d;      // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0]   b_q, b_d;      // multiplier, or divisor magnitude
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Decodes of the incoming request
    logic            acc_c;
    logic            div_sgn_c;
    logic            a_neg_c;
    logic            b_neg_c;
    logic            div_zero_c;
    logic            div_ovf_c;

    assign acc_c      = in_valid && (state_q == S_IDLE) && !flush;
    assign div_sgn_c  = !funct3[0];
    assign a_neg_c    = div_sgn_c && op_a[XLEN-1];
    assign b_neg_c    = div_sgn_c && op_b[XLEN-1];
    assign div_zero_c = (op_b == '0);
    assign div_ovf_c  = div_sgn_c && (op_a == MOST_NEG) && (&op_b);

    // Full-width product: operands sign- or zero-extended to 2*XLEN, product taken modulo 2^(2*XLEN)
    logic [2*XLEN-1:0] a_w, b_w, prod;
    logic              a_sgn, b_sgn;

    assign a_sgn = (f3_q[1:0] == 2'b01) || (f3_q[1:0] == 2'b10);
    assign b_sgn = (f3_q[1:0] == 2'b01);
    assign a_w   = {{XLEN{a_sgn && a_q[XLEN-1]}}, a_q};
    assign b_w   = {{XLEN{b_sgn && b_q[XLEN-1]}}, b_q};
    assign prod  = a_w * b_w;

    // One restoring-division step
    logic [XLEN:0]   rem_sh, diff;
    logic            qbit;
    logic [XLEN-1:0] rem_nx, quo_nx, quo_fix, rem_fix;

    assign rem_sh  = {rem_q, a_q[XLEN-1]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign qbit    = !diff[XLEN];
    assign rem_nx  = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nx  = {a_q[XLEN-2:0], qbit};
    assign quo_fix = negq_q ? (XLEN'(0) - quo_nx) : quo_nx;
    assign rem_fix = negr_q ? (XLEN'(0) - rem_nx) : rem_nx;

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (acc_c) begin
                        f3_d   = funct3;
                        cnt_d  = '0;
                        rem_d  = '0;
                        negq_d = a_neg_c ^ b_neg_c;
                        negr_d = a_neg_c;
                        if (!funct3[2]) begin
                            a_d     = op_a;
                            b_d     = op_b;
                            state_d = S_MUL;
                        end else if (div_zero_c) begin
                            result_d = funct3[1] ? op_a : '1;
                            state_d  = S_DONE;
                        end else if (div_ovf_c) begin
                            result_d = funct3[1] ? '0 : op_a;
                            state_d  = S_DONE;
                        end else begin
                            a_d     = a_neg_c ? (XLEN'(0) - op_a) : op_a;
                            b_d     = b_neg_c ? (XLEN'(0) - op_b) : op_b;
                            state_d = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    result_d = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    state_d  = S_DONE;
                end
                S_DIV: begin
                    a_d   = quo_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_d = f3_q[1] ? rem_fix : quo_fix;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign result    = result_q;

endmodule
